vga_timing_gen: RTL and testbench

Display timing generator driving the VGA connector's sync lines and producing the `video_on` qualifier and pixel coordinates consumed by the colorizer and the pixel-source logic. It runs from the system clock and advances one pixel per internal pixel tick. It generates horizontal and vertical sync, the active-video window, and line/frame strobes. All outputs are registered, so downstream combinational colour logic stays aligned to the sync lines.

---
 rtl/vga_timing_gen_pkg.sv | 45 ++++
 rtl/vga_timing_gen_if.sv | 34 +++
 rtl/vga_timing_gen_pix_tick_gen.sv | 44 ++++
 rtl/vga_timing_gen.sv | 164 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vga_timing_pkg
// Summary  : Shared VGA timing constants (640x480@60 defaults), derived
//            totals, coordinate width and small sizing helpers.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

   // 640x480@60 defaults
   localparam int c_def_clk_div  = 4;
   localparam int c_def_h_active = 640;
   localparam int c_def_h_fp     = 16;
   localparam int c_def_h_sync   = 96;
   localparam int c_def_h_bp     = 48;
   localparam int c_def_v_active = 480;
   localparam int c_def_v_fp     = 10;
   localparam int c_def_v_sync   = 2;
   localparam int c_def_v_bp     = 33;

   localparam int c_def_h_total  = c_def_h_active + c_def_h_fp + c_def_h_sync + c_def_h_bp;
   localparam int c_def_v_total  = c_def_v_active + c_def_v_fp + c_def_v_sync + c_def_v_bp;

   // Coordinate width shared with the colorizer and pixel-source blocks
   localparam int c_coord_w      = 12;

   // Internal counter width and the largest line/frame total it can hold
   localparam int c_cnt_w        = 10;
   localparam int c_cnt_span     = 1 << c_cnt_w;

   localparam int c_max_clk_div  = 16;

   // Sum of the four segments of a line or frame
   function automatic int span_total(input int active, input int fp,
                                     input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   // Prescaler counter width; a divide-by-1 still keeps a 1-bit counter
   function automatic int div_width(input int clk_div);
      return (clk_div > 1) ? $clog2(clk_div) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Interface: vga_timing_gen_if
// Summary  : Display timing bundle: sync lines, video qualifier, pixel
//            coordinates and line/frame strobes.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   logic                 horiz_sync;
   logic                 vert_sync;
   logic                 video_on;
   logic [c_coord_w-1:0] pixel_column;
   logic [c_coord_w-1:0] pixel_row;
   logic                 line_start;
   logic                 frame_start;

   // Timing generator side
   modport master (
      output horiz_sync, vert_sync, video_on,
      output pixel_column, pixel_row,
      output line_start, frame_start
   );

   // Consumers (connector, colorizer, pixel source)
   modport slave (
      input horiz_sync, vert_sync, video_on,
      input pixel_column, pixel_row,
      input line_start, frame_start
   );

endinterface
`default_nettype wire

// File: rtl/vga_timing_gen_pix_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : pix_tick_gen
// Summary  : System-clock prescaler; pix_tick_o is high on the last clock of
//            every CLK_DIV-clock pixel period (always high for CLK_DIV=1).
// Revision : 1.0 - initial release
// ============================================================================
module pix_tick_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = c_def_clk_div
)(
   input  logic clock,
   input  logic reset_n,
   output logic pix_tick_o
);

   localparam int                 c_div_w    = div_width(CLK_DIV);
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

   logic [c_div_w-1:0] div_cnt_q;
   logic [c_div_w-1:0] div_cnt_d;

   // Next prescaler count: wrap after the last clock of the pixel period
   always_comb begin
      div_cnt_d = div_cnt_q + c_div_w'(1);
      if (div_cnt_q == c_div_last) begin
         div_cnt_d = '0;
      end
   end

   // Prescaler register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   assign pix_tick_o = (div_cnt_q == c_div_last);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Summary  : Free-running VGA display timing generator. Holds the horizontal
//            and vertical counters and registers every output from the
//            current counter state, so sync, coordinates and strobes share
//            one clock of latency.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   CLK_DIV    = c_def_clk_div,
   parameter int   H_ACTIVE   = c_def_h_active,
   parameter int   H_FP       = c_def_h_fp,
   parameter int   H_SYNC     = c_def_h_sync,
   parameter int   H_BP       = c_def_h_bp,
   parameter int   V_ACTIVE   = c_def_v_active,
   parameter int   V_FP       = c_def_v_fp,
   parameter int   V_SYNC     = c_def_v_sync,
   parameter int   V_BP       = c_def_v_bp,
   parameter logic H_SYNC_POL = 1'b0,
   parameter logic V_SYNC_POL = 1'b0
)(
   input  logic             clock,
   input  logic             reset_n,
   vga_timing_gen_if.master vga_o
);

   localparam int c_h_total = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int c_v_total = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   // Decode compares run one bit wider so a sync window ending at 1024 fits
   localparam int c_cmp_w = c_cnt_w + 1;

   localparam logic [c_cnt_w-1:0] c_h_last  = c_cnt_w'(c_h_total - 1);
   localparam logic [c_cnt_w-1:0] c_v_last  = c_cnt_w'(c_v_total - 1);
   localparam logic [c_cmp_w-1:0] c_h_act   = c_cmp_w'(H_ACTIVE);
   localparam logic [c_cmp_w-1:0] c_hs_beg  = c_cmp_w'(H_ACTIVE + H_FP);
   localparam logic [c_cmp_w-1:0] c_hs_end  = c_cmp_w'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [c_cmp_w-1:0] c_v_act   = c_cmp_w'(V_ACTIVE);
   localparam logic [c_cmp_w-1:0] c_vs_beg  = c_cmp_w'(V_ACTIVE + V_FP);
   localparam logic [c_cmp_w-1:0] c_vs_end  = c_cmp_w'(V_ACTIVE + V_FP + V_SYNC);

   // Reject parameter sets the 10-bit counters or the prescaler cannot hold
   if (c_h_total > c_cnt_span || c_h_total < 1) begin : g_bad_h_total
      $error("vga_timing_gen: H_TOTAL=%0d outside 1..%0d", c_h_total, c_cnt_span);
   end
   if (c_v_total > c_cnt_span || c_v_total < 1) begin : g_bad_v_total
      $error("vga_timing_gen: V_TOTAL=%0d outside 1..%0d", c_v_total, c_cnt_span);
   end
   if (CLK_DIV < 1 || CLK_DIV > c_max_clk_div) begin : g_bad_clk_div
      $error("vga_timing_gen: CLK_DIV=%0d outside 1..%0d", CLK_DIV, c_max_clk_div);
   end

   logic                 w_pix_tick;
   logic [c_cnt_w-1:0]   h_cnt_q, h_cnt_d;
   logic [c_cnt_w-1:0]   v_cnt_q, v_cnt_d;
   logic                 line_pend_q, line_pend_d;
   logic                 frame_pend_q, frame_pend_d;
   logic [c_cmp_w-1:0]   w_h_ext, w_v_ext;

   logic                 video_on_q, video_on_d;
   logic                 hsync_q, hsync_d;
   logic                 vsync_q, vsync_d;
   logic [c_coord_w-1:0] column_q, column_d;
   logic [c_coord_w-1:0] row_q, row_d;
   logic                 line_start_q;
   logic                 frame_start_q;

   pix_tick_gen #(
      .CLK_DIV    (CLK_DIV)
   ) u_pix_tick (
      .clock      (clock),
      .reset_n    (reset_n),
      .pix_tick_o (w_pix_tick)
   );

   // Counter advance; a wrap arms a pending flag that becomes the strobe on
   // the very next clock, when the outputs first show column 0
   always_comb begin
      h_cnt_d      = h_cnt_q;
      v_cnt_d      = v_cnt_q;
      line_pend_d  = 1'b0;
      frame_pend_d = 1'b0;
      if (w_pix_tick) begin
         if (h_cnt_q == c_h_last) begin
            h_cnt_d     = '0;
            line_pend_d = 1'b1;
            if (v_cnt_q == c_v_last) begin
               v_cnt_d      = '0;
               frame_pend_d = 1'b1;
            end else begin
               v_cnt_d = v_cnt_q + c_cnt_w'(1);
            end
         end else begin
            h_cnt_d = h_cnt_q + c_cnt_w'(1);
         end
      end
   end

   // Counter and pending-strobe registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt_q      <= '0;
         v_cnt_q      <= '0;
         line_pend_q  <= 1'b0;
         frame_pend_q <= 1'b0;
      end else begin
         h_cnt_q      <= h_cnt_d;
         v_cnt_q      <= v_cnt_d;
         line_pend_q  <= line_pend_d;
         frame_pend_q <= frame_pend_d;
      end
   end

   // Output decode from the current counter state
   always_comb begin
      w_h_ext    = c_cmp_w'(h_cnt_q);
      w_v_ext    = c_cmp_w'(v_cnt_q);
      video_on_d = (w_h_ext < c_h_act) && (w_v_ext < c_v_act);
      hsync_d    = ~H_SYNC_POL;
      vsync_d    = ~V_SYNC_POL;
      if (w_h_ext >= c_hs_beg && w_h_ext < c_hs_end) begin
         hsync_d = H_SYNC_POL;
      end
      if (w_v_ext >= c_vs_beg && w_v_ext < c_vs_end) begin
         vsync_d = V_SYNC_POL;
      end
      column_d   = c_coord_w'(h_cnt_q);
      row_d      = c_coord_w'(v_cnt_q);
   end

   // Output registers, updated every clock so sync and coordinates never skew
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         video_on_q    <= 1'b0;
         hsync_q       <= ~H_SYNC_POL;
         vsync_q       <= ~V_SYNC_POL;
         column_q      <= '0;
         row_q         <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         video_on_q    <= video_on_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         column_q      <= column_d;
         row_q         <= row_d;
         line_start_q  <= line_pend_q;
         frame_start_q <= frame_pend_q;
      end
   end

   assign vga_o.horiz_sync   = hsync_q;
   assign vga_o.vert_sync    = vsync_q;
   assign vga_o.video_on     = video_on_q;
   assign vga_o.pixel_column = column_q;
   assign vga_o.pixel_row    = row_q;
   assign vga_o.line_start   = line_start_q;
   assign vga_o.frame_start  = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Summary  : Self-checking bench for vga_timing_gen. Instance A uses the
//            640x480 defaults; instance B uses CLK_DIV=1, active-high syncs
//            and a short 10-line frame so frame wraps come quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   localparam int   A_DIV = 4, A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
   localparam int   A_VA = 480, A_VF = 10, A_VS = 2, A_VB = 33;
   localparam logic A_HP = 1'b0, A_VP = 1'b0;
   localparam int   B_DIV = 1, B_HA = 640, B_HF = 16, B_HS = 96, B_HB = 48;
   localparam int   B_VA = 6, B_VF = 1, B_VS = 2, B_VB = 1;
   localparam logic B_HP = 1'b1, B_VP = 1'b1;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        von;
      logic [11:0] col;
      logic [11:0] row;
      logic        ls;
      logic        fs;
   } vout_t;

   typedef struct {
      int unsigned n;
      vout_t       exp;
   } vec_t;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;
   logic        chk_en  = 1'b0;
   int unsigned cyc     = 0;
   int          nvec    = 0;
   int          nbad    = 0;

   vga_timing_gen_if ifa ();
   vga_timing_gen_if ifb ();

   vga_timing_gen #(
      .CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
      .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
      .H_SYNC_POL(A_HP), .V_SYNC_POL(A_VP)
   ) dut_a (.clock(clock), .reset_n(reset_n), .vga_o(ifa));

   vga_timing_gen #(
      .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
      .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
      .H_SYNC_POL(B_HP), .V_SYNC_POL(B_VP)
   ) dut_b (.clock(clock), .reset_n(reset_n), .vga_o(ifb));

   vout_t a_out, b_out;
   assign a_out = {ifa.horiz_sync, ifa.vert_sync, ifa.video_on, ifa.pixel_column,
                   ifa.pixel_row, ifa.line_start, ifa.frame_start};
   assign b_out = {ifb.horiz_sync, ifb.vert_sync, ifb.video_on, ifb.pixel_column,
                   ifb.pixel_row, ifb.line_start, ifb.frame_start};

   always #5 clock = ~clock;

   // Clock edges seen since the last reset release
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   // Reference: the output after edge n shows pixel state (n-1)/DIV of an
   // endless raster; strobes mark the first clock of a (wrapped) column 0.
   function automatic vout_t model(input int inst, input int unsigned n);
      int   div, ha, hf, hsw, hb, va, vf, vsw, vb;
      int   htot, vtot, s, ph, h, v;
      logic hp, vp;
      vout_t o;
      if (inst == 0) begin
         div = A_DIV; ha = A_HA; hf = A_HF; hsw = A_HS; hb = A_HB;
         va = A_VA; vf = A_VF; vsw = A_VS; vb = A_VB; hp = A_HP; vp = A_VP;
      end else begin
         div = B_DIV; ha = B_HA; hf = B_HF; hsw = B_HS; hb = B_HB;
         va = B_VA; vf = B_VF; vsw = B_VS; vb = B_VB; hp = B_HP; vp = B_VP;
      end
      htot = ha + hf + hsw + hb;
      vtot = va + vf + vsw + vb;
      o = '0;
      if (n == 0) begin
         o.hs = ~hp;
         o.vs = ~vp;
         return o;
      end
      s  = (int'(n) - 1) / div;
      ph = (int'(n) - 1) % div;
      h  = s % htot;
      v  = (s / htot) % vtot;
      o.col = 12'(h);
      o.row = 12'(v);
      o.von = (h < ha) && (v < va);
      o.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
      o.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
      o.ls  = (ph == 0) && (s != 0) && (h == 0);
      o.fs  = o.ls && (v == 0);
      return o;
   endfunction

   function automatic vout_t mk(input logic hs, input logic vs, input logic von,
                                input int col, input int row,
                                input logic ls, input logic fs);
      vout_t o;
      o.hs = hs; o.vs = vs; o.von = von;
      o.col = 12'(col); o.row = 12'(row);
      o.ls = ls; o.fs = fs;
      return o;
   endfunction

   task automatic check_out(input string name, input vout_t act, input vout_t exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s @cyc %0d: got hs=%b vs=%b von=%b col=%0d row=%0d ls=%b fs=%b, expected hs=%b vs=%b von=%b col=%0d row=%0d ls=%b fs=%b",
                  name, cyc, act.hs, act.vs, act.von, act.col, act.row, act.ls, act.fs,
                  exp.hs, exp.vs, exp.von, exp.col, exp.row, exp.ls, exp.fs);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nbad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return a_out.von;
         1:       return a_out.hs;
         2:       return a_out.ls;
         3:       return b_out.hs;
         4:       return b_out.ls;
         5:       return b_out.vs;
         6:       return b_out.fs;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_sig(input int sel, input logic lvl, input int bound);
      int k;
      k = 0;
      while (sig(sel) !== lvl) begin
         @(negedge clock);
         k++;
         if (k > bound) begin
            nvec++;
            nbad++;
            $display("FAIL wait_sel%0d: waited %0d clocks for %b, got %b", sel, k, lvl, sig(sel));
            return;
         end
      end
   endtask

   task automatic run_len(input int sel, input logic lvl, input int bound, output int len);
      len = 0;
      while (sig(sel) === lvl && len <= bound) begin
         @(negedge clock);
         len++;
      end
   endtask

   task automatic wait_coord_b(input int col, input int row, input int bound);
      int k;
      k = 0;
      while (!(b_out.col == 12'(col) && b_out.row == 12'(row)) && k <= bound) begin
         @(negedge clock);
         k++;
      end
      if (k > bound) begin
         nvec++;
         nbad++;
         $display("FAIL wait_b_%0d_%0d: not reached in %0d clocks, at col=%0d row=%0d",
                  col, row, k, b_out.col, b_out.row);
      end
   endtask

   // Every clock, both instances against the reference raster
   always @(negedge clock) begin
      if (chk_en) begin
         check_out("model_a", a_out, model(0, cyc));
         check_out("model_b", b_out, model(1, cyc));
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[13];
      int   len, per, guard, gap, hold;

      // Instance A after release: hand-derived column/row/sync boundaries
      tbl[0]  = '{1,    mk(1, 1, 1,   0, 0, 0, 0)};
      tbl[1]  = '{4,    mk(1, 1, 1,   0, 0, 0, 0)};
      tbl[2]  = '{5,    mk(1, 1, 1,   1, 0, 0, 0)};
      tbl[3]  = '{2560, mk(1, 1, 1, 639, 0, 0, 0)};
      tbl[4]  = '{2561, mk(1, 1, 0, 640, 0, 0, 0)};
      tbl[5]  = '{2624, mk(1, 1, 0, 655, 0, 0, 0)};
      tbl[6]  = '{2625, mk(0, 1, 0, 656, 0, 0, 0)};
      tbl[7]  = '{3008, mk(0, 1, 0, 751, 0, 0, 0)};
      tbl[8]  = '{3009, mk(1, 1, 0, 752, 0, 0, 0)};
      tbl[9]  = '{3200, mk(1, 1, 0, 799, 0, 0, 0)};
      tbl[10] = '{3201, mk(1, 1, 1,   0, 1, 1, 0)};
      tbl[11] = '{3202, mk(1, 1, 1,   0, 1, 0, 0)};
      tbl[12] = '{6401, mk(1, 1, 1,   0, 2, 1, 0)};

      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_en = 1'b1;
      check_out("reset_a", a_out, mk(1, 1, 0, 0, 0, 0, 0));
      check_out("reset_b", b_out, mk(0, 0, 0, 0, 0, 0, 0));
      reset_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         guard = 0;
         while (cyc < tbl[i].n && guard < 10000) begin
            @(negedge clock);
            guard++;
         end
         check_out($sformatf("vec%0d", i), a_out, tbl[i].exp);
      end

      // A: active window length and blanking length
      wait_sig(0, 1'b0, 4000);
      wait_sig(0, 1'b1, 4000);
      run_len(0, 1'b1, 5000, len);
      check_int("a_video_on_high", len, 2560);
      run_len(0, 1'b0, 5000, len);
      check_int("a_video_on_low", len, 640);

      // A: active-low hsync starts at column 656 and lasts 96 pixels
      wait_sig(1, 1'b1, 4000);
      wait_sig(1, 1'b0, 4000);
      check_int("a_hsync_start_col", int'(a_out.col), 656);
      run_len(1, 1'b0, 5000, len);
      check_int("a_hsync_len", len, 384);

      // A: line_start period
      wait_sig(2, 1'b1, 4000);
      per = 0;
      do begin
         @(negedge clock);
         per++;
      end while (sig(2) !== 1'b1 && per <= 4000);
      check_int("a_line_period", per, 3200);

      // B: active-high hsync, CLK_DIV=1
      wait_sig(3, 1'b0, 1000);
      wait_sig(3, 1'b1, 1000);
      check_int("b_hsync_start_col", int'(b_out.col), 656);
      run_len(3, 1'b1, 2000, len);
      check_int("b_hsync_len", len, 96);

      wait_sig(4, 1'b1, 1000);
      per = 0;
      do begin
         @(negedge clock);
         per++;
      end while (sig(4) !== 1'b1 && per <= 1000);
      check_int("b_line_period", per, 800);

      // B: vsync spans exactly rows 7 and 8
      wait_sig(5, 1'b0, 10000);
      wait_sig(5, 1'b1, 10000);
      check_int("b_vsync_start_row", int'(b_out.row), 7);
      run_len(5, 1'b1, 3000, len);
      check_int("b_vsync_len", len, 1600);
      check_int("b_vsync_end_row", int'(b_out.row), 9);

      // B: frame wrap from (799,9) to (0,0) with both strobes for one clock
      wait_coord_b(799, 9, 10000);
      @(negedge clock);
      check_out("b_wrap", b_out, mk(0, 0, 1, 0, 0, 1, 1));
      @(negedge clock);
      check_out("b_wrap_next", b_out, mk(0, 0, 1, 1, 0, 0, 0));
      per = 1;
      while (b_out.fs !== 1'b1 && per <= 10000) begin
         @(negedge clock);
         per++;
      end
      check_int("b_frame_period", per, 8000);

      // Asynchronous reset mid-frame, then a clean restart at (0,0)
      wait_coord_b(400, 5, 10000);
      @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      check_out("midreset_a", a_out, mk(1, 1, 0, 0, 0, 0, 0));
      check_out("midreset_b", b_out, mk(0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check_out("restart_a", a_out, mk(1, 1, 1, 0, 0, 0, 0));
      check_out("restart_b", b_out, mk(0, 0, 1, 0, 0, 0, 0));

      // Random reset pulses at random points; the per-clock model check covers them
      repeat (4) begin
         gap = int'($urandom_range(100, 2500));
         repeat (gap) @(negedge clock);
         #($urandom_range(1, 4));
         reset_n = 1'b0;
         hold = int'($urandom_range(1, 4));
         repeat (hold) @(negedge clock);
         reset_n = 1'b1;
      end
      repeat (200) @(negedge clock);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
`default_nettype wire
